// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares one single-ported data memory between the CPU load/store port (A)
// and a secondary master (B). One access is granted per cycle. Plain
// contention is resolved round-robin. An owner holding lock keeps the
// memory until it has taken MAX_BURST beats while the other port waits.
// Read data is registered and flagged by a one-cycle rvalid strobe.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   a_* / b_*             requester ports: req, we, lock, addr, wdata in;
//                         gnt (combinational), rdata, rvalid (registered) out
//   mem_addr/wdata/we     drive to memory (writes commit on clk rise)
//   mem_rdata             combinational read data from memory
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 1024,
    parameter int ADD_SIZE  = $clog2(DEPTH),
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_req,
    input  logic                a_we,
    input  logic                a_lock,
    input  logic [ADD_SIZE-1:0] a_addr,
    input  logic [WIDTH-1:0]    a_wdata,
    input  logic                b_req,
    input  logic                b_we,
    input  logic                b_lock,
    input  logic [ADD_SIZE-1:0] b_addr,
    input  logic [WIDTH-1:0]    b_wdata,
    output logic                a_gnt,
    output logic                b_gnt,
    output logic [WIDTH-1:0]    a_rdata,
    output logic [WIDTH-1:0]    b_rdata,
    output logic                a_rvalid,
    output logic                b_rvalid,
    output logic [ADD_SIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    output logic                mem_we,
    input  logic [WIDTH-1:0]    mem_rdata
);

    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    state_t            state, state_next;
    port_t             last, last_next;
    logic [CNT_W-1:0]  burst_cnt, cnt_next;

    // State register.
    // NOTE: sequential blocks use non-blocking assignments so every register
    // updates from the values present before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last      <= PORT_B;        // A wins the first tie
            burst_cnt <= '0;
        end else begin
            state     <= state_next;
            last      <= last_next;
            burst_cnt <= cnt_next;
        end
    end

    // Grant selection, next state and memory drive.
    // NOTE: every signal assigned here gets a default first, so no path
    // through the block can leave a latch behind.
    always_comb begin
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        state_next = IDLE;
        last_next  = last;
        cnt_next   = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;

        // Grants are gated by reset so nothing reaches memory while held.
        if (rst) begin
            if (state == LOCK_A && a_req) begin
                // The burst limit only preempts a contested owner.
                if (burst_cnt == CNT_MAX && b_req) b_gnt = 1'b1;
                else                               a_gnt = 1'b1;
            end else if (state == LOCK_B && b_req) begin
                if (burst_cnt == CNT_MAX && a_req) a_gnt = 1'b1;
                else                               b_gnt = 1'b1;
            end else if (a_req && b_req) begin
                if (last == PORT_B) a_gnt = 1'b1;
                else                b_gnt = 1'b1;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end

        if (a_gnt) begin
            last_next = PORT_A;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
            mem_we    = a_we;
            if (a_lock) begin
                state_next = LOCK_A;
                if (state != LOCK_A)         cnt_next = CNT_W'(1);
                else if (burst_cnt == CNT_MAX) cnt_next = CNT_MAX;
                else                         cnt_next = burst_cnt + CNT_W'(1);
            end
        end else if (b_gnt) begin
            last_next = PORT_B;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
            mem_we    = b_we;
            if (b_lock) begin
                state_next = LOCK_B;
                if (state != LOCK_B)         cnt_next = CNT_W'(1);
                else if (burst_cnt == CNT_MAX) cnt_next = CNT_MAX;
                else                         cnt_next = burst_cnt + CNT_W'(1);
            end
        end
    end

    // Read return path: data captured at the granting edge, presented the
    // following cycle. rdata holds between reads; rvalid is a single strobe.
    // NOTE: the read-data registers are reset because their reset value is
    // visible on the ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_rdata  <= '0;
            b_rdata  <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= a_gnt && !a_we;
            b_rvalid <= b_gnt && !b_we;
            if (a_gnt && !a_we) a_rdata <= mem_rdata;
            if (b_gnt && !b_we) b_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

    localparam int WIDTH = 16;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int MAXB  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [AW-1:0]    a_addr, b_addr;
    logic [WIDTH-1:0] a_wdata, b_wdata;
    logic             a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we;
    logic [WIDTH-1:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]    mem_addr;

    int tests_run    = 0;
    int tests_failed = 0;

    data_mem_arbiter #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADD_SIZE(AW), .MAX_BURST(MAXB)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rdata(a_rdata), .b_rdata(b_rdata),
        .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Known preload so every address has a predictable value.
    function automatic logic [WIDTH-1:0] init_val(input int i);
        return 16'((i * 40503) ^ 23130);
    endfunction

    // Memory: combinational read, synchronous write.
    logic [WIDTH-1:0] mem [DEPTH];
    assign mem_rdata = mem[mem_addr];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = init_val(i);
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    // ---------------- reference model ----------------
    typedef struct {
        logic             valid;
        logic             we;
        logic             lock;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] wdata;
    } req_t;

    int               m_owner;   // -1 nobody holds the lock, 0 = A, 1 = B
    int               m_beats;   // consecutive locked beats taken by owner
    int               m_last;    // last port granted
    logic [WIDTH-1:0] m_rdata  [2];
    logic             m_rvalid [2];
    logic [WIDTH-1:0] ref_mem  [DEPTH];

    task automatic model_reset();
        m_owner = -1; m_beats = 0; m_last = 1;
        for (int p = 0; p < 2; p++) begin m_rdata[p] = '0; m_rvalid[p] = 1'b0; end
    endtask

    function automatic int predict(input logic ar, input logic br);
        logic rq [2];
        rq[0] = ar; rq[1] = br;
        if (m_owner >= 0 && rq[m_owner])
            return (m_beats >= MAXB && rq[1 - m_owner]) ? 1 - m_owner : m_owner;
        if (ar && br) return 1 - m_last;
        if (ar) return 0;
        if (br) return 1;
        return -1;
    endfunction

    task automatic model_edge(input int w, input req_t r);
        m_rvalid[0] = 1'b0; m_rvalid[1] = 1'b0;
        if (w < 0) begin
            m_owner = -1; m_beats = 0;
            return;
        end
        m_last = w;
        if (r.we) ref_mem[r.addr] = r.wdata;
        else begin m_rdata[w] = ref_mem[r.addr]; m_rvalid[w] = 1'b1; end
        if (r.lock) begin
            m_beats = (m_owner == w) ? ((m_beats + 1 > MAXB) ? MAXB : m_beats + 1) : 1;
            m_owner = w;
        end else begin
            m_owner = -1; m_beats = 0;
        end
    endtask

    // ---------------- helpers (stimulus only) ----------------
    task automatic clear_inputs();
        a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        a_req = 1; a_we = 1; a_addr = 3; a_wdata = 16'hdead; b_req = 1; b_addr = 4;
        @(negedge clk);
        tests_run++; if (a_gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_a_gnt: got %b want 0", a_gnt); end
        tests_run++; if (b_gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_b_gnt: got %b want 0", b_gnt); end
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        tests_run++; if (mem_addr !== '0 || mem_wdata !== '0) begin tests_failed++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata); end
        tests_run++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid: got %b%b want 00", a_rvalid, b_rvalid); end
        tests_run++; if (a_rdata !== '0 || b_rdata !== '0) begin tests_failed++; $display("FAIL reset_rdata: got %h/%h want 0/0", a_rdata, b_rdata); end
        @(posedge clk);
        #1 a_we = 0; rst = 1'b1;
        #1;
        tests_run++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_first_grant: got a=%b b=%b want a=1 b=0", a_gnt, b_gnt); end
        tests_run++; if (mem_addr !== AW'(3)) begin tests_failed++; $display("FAIL reset_first_addr: got %0d want 3", mem_addr); end
        @(posedge clk);
        #1 clear_inputs();
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            automatic logic exp_a = (i % 2 == 0);
            a_req = 1; a_we = 1; a_addr = 5; a_wdata = 16'h1234;
            b_req = 1; b_we = 0; b_addr = 5;
            @(negedge clk);
            tests_run++; if (a_gnt !== exp_a || b_gnt !== !exp_a) begin tests_failed++; $display("FAIL rr_grant[%0d]: got a=%b b=%b want a=%b", i, a_gnt, b_gnt, exp_a); end
            tests_run++; if (mem_we !== exp_a || mem_addr !== AW'(5)) begin tests_failed++; $display("FAIL rr_mem[%0d]: got we=%b addr=%0d want we=%b addr=5", i, mem_we, mem_addr, exp_a); end
            if (i >= 2 && exp_a) begin
                tests_run++; if (b_rvalid !== 1'b1 || b_rdata !== 16'h1234) begin tests_failed++; $display("FAIL rr_b_read[%0d]: got v=%b d=%h want v=1 d=1234", i, b_rvalid, b_rdata); end
            end
            if (!exp_a) begin
                tests_run++; if (b_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rr_b_rvalid[%0d]: got %b want 0", i, b_rvalid); end
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

    task automatic test_locked_burst_uncontested();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            a_req = 1; a_we = 1; a_lock = 1; a_addr = AW'(i); a_wdata = 16'ha000 + 16'(i);
            @(negedge clk);
            tests_run++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin tests_failed++; $display("FAIL burst_grant[%0d]: got a=%b b=%b want a=1 b=0", i, a_gnt, b_gnt); end
            tests_run++; if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== 16'ha000 + 16'(i)) begin
                tests_failed++; $display("FAIL burst_mem[%0d]: got we=%b addr=%0d d=%h", i, mem_we, mem_addr, mem_wdata); end
            @(posedge clk);
            #1;
        end
        // Count is held at the limit, so a newly arriving B preempts at once.
        a_addr = 8; a_wdata = 16'ha008;
        b_req = 1; b_we = 0; b_addr = 3;
        @(negedge clk);
        tests_run++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin tests_failed++; $display("FAIL burst_saturated_preempt: got a=%b b=%b want a=0 b=1", a_gnt, b_gnt); end
        @(posedge clk);
        #1 b_req = 0;
        @(negedge clk);
        tests_run++; if (a_gnt !== 1'b1) begin tests_failed++; $display("FAIL burst_resume: got a=%b want 1", a_gnt); end
        tests_run++; if (b_rvalid !== 1'b1 || b_rdata !== 16'ha003) begin tests_failed++; $display("FAIL burst_b_read: got v=%b d=%h want v=1 d=a003", b_rvalid, b_rdata); end
        @(posedge clk);
        #1 clear_inputs();
    endtask

    task automatic test_burst_limit();
        automatic logic pattern [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        automatic int na = 0, last_a = 0;
        automatic logic prev_a = 0, prev_b = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            a_req = 1; a_we = 0; a_lock = 1; a_addr = AW'(100 + na);
            b_req = 1; b_we = 0; b_lock = 0; b_addr = 600;
            @(negedge clk);
            tests_run++; if (b_gnt !== pattern[i] || a_gnt !== !pattern[i]) begin tests_failed++; $display("FAIL limit_grant[%0d]: got a=%b b=%b want b=%b", i, a_gnt, b_gnt, pattern[i]); end
            if (prev_a) begin
                tests_run++; if (a_rvalid !== 1'b1 || a_rdata !== init_val(last_a)) begin tests_failed++; $display("FAIL limit_a_read[%0d]: got v=%b d=%h want v=1 d=%h", i, a_rvalid, a_rdata, init_val(last_a)); end
            end else begin
                tests_run++; if (a_rvalid !== 1'b0) begin tests_failed++; $display("FAIL limit_a_rvalid[%0d]: got %b want 0", i, a_rvalid); end
            end
            tests_run++; if (b_rvalid !== prev_b) begin tests_failed++; $display("FAIL limit_b_rvalid[%0d]: got %b want %b", i, b_rvalid, prev_b); end
            prev_a = !pattern[i];
            prev_b = pattern[i];
            if (!pattern[i]) begin last_a = 100 + na; na++; end
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            a_req = 1; a_we = 0; a_lock = 1; a_addr = AW'(200 + i);
            @(negedge clk);
            tests_run++; if (a_gnt !== 1'b1) begin tests_failed++; $display("FAIL midrst_beat[%0d]: got %b want 1", i, a_gnt); end
            @(posedge clk);
            #1;
        end
        a_addr = 202;
        #2;
        tests_run++; if (a_gnt !== 1'b1 || a_rvalid !== 1'b1 || a_rdata !== init_val(201)) begin
            tests_failed++; $display("FAIL midrst_beat3: got g=%b v=%b d=%h want g=1 v=1 d=%h", a_gnt, a_rvalid, a_rdata, init_val(201)); end
        rst = 1'b0;
        #1;
        tests_run++; if (a_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0) begin tests_failed++; $display("FAIL midrst_gnt_drop: got g=%b we=%b addr=%0d", a_gnt, mem_we, mem_addr); end
        tests_run++; if (a_rvalid !== 1'b0 || a_rdata !== '0) begin tests_failed++; $display("FAIL midrst_rdata: got v=%b d=%h want v=0 d=0", a_rvalid, a_rdata); end
        // A write presented across an edge with reset low must not commit.
        a_we = 1; a_addr = 250; a_wdata = 16'hffff;
        @(posedge clk);
        #1 clear_inputs();
        b_req = 1; b_we = 0; b_addr = 250;
        rst = 1'b1;
        model_reset();
        #1;
        tests_run++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0 || mem_addr !== AW'(250)) begin tests_failed++; $display("FAIL midrst_b_first: got a=%b b=%b addr=%0d", a_gnt, b_gnt, mem_addr); end
        @(posedge clk);
        #1 b_req = 0;
        @(negedge clk);
        tests_run++; if (b_rvalid !== 1'b1 || b_rdata !== init_val(250)) begin tests_failed++; $display("FAIL midrst_no_commit: got v=%b d=%h want v=1 d=%h", b_rvalid, b_rdata, init_val(250)); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_idle_hold();
        apply_reset();
        b_req = 1; b_we = 1; b_addr = 9; b_wdata = 16'hbeef;
        @(negedge clk);
        tests_run++; if (b_gnt !== 1'b1) begin tests_failed++; $display("FAIL idle_setup: got %b want 1", b_gnt); end
        @(posedge clk);
        #1 clear_inputs();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || mem_addr !== '0 || mem_we !== 1'b0) begin
                tests_failed++; $display("FAIL idle_quiet[%0d]: got g=%b%b addr=%0d we=%b", i, a_gnt, b_gnt, mem_addr, mem_we); end
            @(posedge clk);
            #1;
        end
        a_req = 1; a_we = 0; a_addr = 9;
        @(negedge clk);
        tests_run++; if (a_gnt !== 1'b1 || mem_addr !== AW'(9)) begin tests_failed++; $display("FAIL idle_read_grant: got g=%b addr=%0d", a_gnt, mem_addr); end
        @(posedge clk);
        #1 clear_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++; if (a_rvalid !== (i == 0) || a_rdata !== 16'hbeef) begin
                tests_failed++; $display("FAIL idle_read_hold[%0d]: got v=%b d=%h want v=%b d=beef", i, a_rvalid, a_rdata, (i == 0)); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        a_req = 1; a_we = 0; a_addr = 20;
        @(posedge clk);
        #1 clear_inputs();
        b_req = 1; b_we = 1; b_addr = 20; b_wdata = 16'h5555;
        @(negedge clk);
        tests_run++; if (b_gnt !== 1'b1 || a_rvalid !== 1'b1 || a_rdata !== init_val(20)) begin
            tests_failed++; $display("FAIL b2b_prewrite: got g=%b v=%b d=%h want d=%h", b_gnt, a_rvalid, a_rdata, init_val(20)); end
        @(posedge clk);
        #1 clear_inputs();
        a_req = 1; a_we = 0; a_addr = 20;
        @(posedge clk);
        #1 clear_inputs();
        @(negedge clk);
        tests_run++; if (a_rvalid !== 1'b1 || a_rdata !== 16'h5555) begin tests_failed++; $display("FAIL b2b_postwrite: got v=%b d=%h want v=1 d=5555", a_rvalid, a_rdata); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        req_t pend [2];
        int   w;
        logic            exp_we;
        logic [AW-1:0]   exp_addr;
        logic [WIDTH-1:0] exp_wd;
        apply_reset();
        for (int p = 0; p < 2; p++) pend[p].valid = 1'b0;
        for (int c = 0; c < 500; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p].valid && $urandom_range(0, 3) != 0) begin
                    pend[p].valid = 1'b1;
                    pend[p].we    = 1'($urandom_range(0, 1));
                    pend[p].lock  = ($urandom_range(0, 9) < 7);
                    pend[p].addr  = AW'(512 + $urandom_range(0, 15));
                    pend[p].wdata = 16'($urandom);
                end
            end
            a_req = pend[0].valid; a_we = pend[0].we; a_lock = pend[0].lock; a_addr = pend[0].addr; a_wdata = pend[0].wdata;
            b_req = pend[1].valid; b_we = pend[1].we; b_lock = pend[1].lock; b_addr = pend[1].addr; b_wdata = pend[1].wdata;
            @(negedge clk);
            w = predict(pend[0].valid, pend[1].valid);
            exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
            if (w >= 0) begin exp_we = pend[w].we; exp_addr = pend[w].addr; exp_wd = pend[w].wdata; end
            tests_run++; if (a_gnt !== (w == 0) || b_gnt !== (w == 1)) begin tests_failed++; $display("FAIL rand_grant[%0d]: got a=%b b=%b want port %0d", c, a_gnt, b_gnt, w); end
            tests_run++; if (mem_we !== exp_we || mem_addr !== exp_addr || mem_wdata !== exp_wd) begin
                tests_failed++; $display("FAIL rand_mem[%0d]: got %b/%0d/%h want %b/%0d/%h", c, mem_we, mem_addr, mem_wdata, exp_we, exp_addr, exp_wd); end
            tests_run++; if (a_rvalid !== m_rvalid[0] || b_rvalid !== m_rvalid[1]) begin tests_failed++; $display("FAIL rand_rvalid[%0d]: got %b%b want %b%b", c, a_rvalid, b_rvalid, m_rvalid[0], m_rvalid[1]); end
            tests_run++; if (a_rdata !== m_rdata[0] || b_rdata !== m_rdata[1]) begin tests_failed++; $display("FAIL rand_rdata[%0d]: got %h/%h want %h/%h", c, a_rdata, b_rdata, m_rdata[0], m_rdata[1]); end
            @(posedge clk);
            if (w >= 0) begin
                model_edge(w, pend[w]);
                pend[w].valid = 1'b0;
            end else begin
                model_edge(w, pend[0]);
            end
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        clear_inputs();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        model_reset();
        test_reset();
        test_round_robin();
        test_locked_burst_uncontested();
        test_burst_limit();
        test_reset_mid_burst();
        test_idle_hold();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
